// File: rtl/bp_pkg.sv
// Shared types for the branch target buffer: entry layout, 2-bit direction
// counter encodings and the saturating counter update.
package bp_pkg;

    localparam int PC_W      = 32;
    localparam int TGT_W     = 30;
    // Widest tag, reached at the smallest table (4 entries).
    localparam int MAX_TAG_W = 28;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [TGT_W-1:0]     target;
        ctr_e                 ctr;
    } entry_t;

    function automatic ctr_e ctr_next(input ctr_e ctr, input logic taken);
        ctr_e nxt;
        nxt = ctr;
        case (ctr)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = CTR_WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup, execute-update and statistics signals of the branch predictor.
interface branch_predictor_if;

    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        inv_all;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    modport master (
        output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_mispredict, inv_all,
        input  pred_taken, pred_target, branch_cnt, mispred_cnt
    );

    modport slave (
        input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_mispredict, inv_all,
        output pred_taken, pred_target, branch_cnt, mispred_cnt
    );

endinterface

// File: rtl/bp_counter_stats.sv
// Resolved-branch and mispredict counters; both wrap naturally at 2^32.
module bp_counter_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_upd_valid,
    input  logic        i_upd_mispredict,
    output logic [31:0] o_branch_cnt,
    output logic [31:0] o_mispred_cnt
);

    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (i_upd_valid) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
            if (i_upd_mispredict)
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign o_branch_cnt  = r_branch_cnt;
    assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup of the
// fetch PC, training/allocation from execute, bulk invalidate and statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    entry_t                r_table [ENTRIES];

    logic [IDX_W-1:0]      w_f_idx;
    logic [MAX_TAG_W-1:0]  w_f_tag;
    logic                  w_f_hit;
    logic [IDX_W-1:0]      w_u_idx;
    logic [MAX_TAG_W-1:0]  w_u_tag;
    logic                  w_u_hit;

    // Tags are stored zero-extended so the entry layout is independent of ENTRIES.
    assign w_f_idx = bus.fetch_pc[IDX_W+1:2];
    assign w_f_tag = MAX_TAG_W'(bus.fetch_pc[31:IDX_W+2]);
    assign w_u_idx = bus.upd_pc[IDX_W+1:2];
    assign w_u_tag = MAX_TAG_W'(bus.upd_pc[31:IDX_W+2]);

    assign w_f_hit = r_table[w_f_idx].valid && (r_table[w_f_idx].tag == w_f_tag);
    assign w_u_hit = r_table[w_u_idx].valid && (r_table[w_u_idx].tag == w_u_tag);

    assign bus.pred_taken  = w_f_hit & r_table[w_f_idx].ctr[1];
    assign bus.pred_target = bus.pred_taken ? {r_table[w_f_idx].target, 2'b00} : 32'd0;

    // NOTE: the whole table is reset because its post-reset contents (counters
    // at weak-not-taken) are visible behaviour, not don't-care storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++)
                r_table[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
        end else begin
            if (bus.inv_all) begin
                for (int i = 0; i < ENTRIES; i++)
                    r_table[i].valid <= 1'b0;
            end
            if (bus.upd_valid) begin
                if (w_u_hit) begin
                    r_table[w_u_idx].ctr <= ctr_next(r_table[w_u_idx].ctr, bus.upd_taken);
                    if (bus.upd_taken)
                        r_table[w_u_idx].target <= bus.upd_target[31:2];
                end else if (bus.upd_taken && !bus.inv_all) begin
                    // Invalidate wins over allocation in the same cycle.
                    r_table[w_u_idx] <= '{valid:  1'b1,
                                          tag:    w_u_tag,
                                          target: bus.upd_target[31:2],
                                          ctr:    CTR_WT};
                end
            end
        end
    end

    bp_counter_stats u_stats (
        .clk              (clk),
        .rst              (rst),
        .i_upd_valid      (bus.upd_valid),
        .i_upd_mispredict (bus.upd_mispredict),
        .o_branch_cnt     (bus.branch_cnt),
        .o_mispred_cnt    (bus.mispred_cnt)
    );

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting in the fetch stage directly upstream of the IF/ID pipeline register. Each cycle it looks up the current fetch PC and supplies a predicted-taken flag and target that the PC-select logic uses to form the next PC, and that travel down the pipeline alongside the fetched instruction. The execute stage reports each resolved branch back, and the block trains its counters, allocates and replaces entries, and keeps branch/mispredict statistics.

## Interface
- ENTRIES, 16: number of BTB entries; power of two, 4..256.
- IDX_W, $clog2(ENTRIES): index width, derived; not overridden.
- TAG_W, 30-IDX_W: tag width (PC[31:IDX_W+2]), derived.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- fetch_pc  input  32  PC being fetched this cycle.
- pred_taken  output  1  combinational; 1 = predict taken.
- pred_target  output  32  combinational; predicted target, 0 when pred_taken=0.
- upd_valid  input  1  EX reports a resolved conditional branch or JAL this cycle.
- upd_pc  input  32  PC of the resolved instruction.
- upd_taken  input  1  actual outcome.
- upd_target  input  32  actual target (meaningful when upd_taken=1).
- upd_mispredict  input  1  EX detected a wrong prediction (direction or target).
- inv_all  input  1  synchronous invalidate of all entries (fence.i / context change).
- branch_cnt  output  32  resolved-branch count.
- mispred_cnt  output  32  mispredict count.

## Operation
- Index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2]. PC[1:0] ignored.
- Entry = {valid, tag, target[31:2], ctr[1:0]}; target[1:0] stored implicitly as 00.
- Lookup (combinational): hit = valid & tag match; pred_taken = hit & ctr[1]; pred_target = {target,2'b00} when pred_taken, else 0.
- Update on upd_valid=1, at the clock edge:
  - Hit, taken: ctr saturating +1 (11 stays 11); target overwritten with upd_target.
  - Hit, not taken: ctr saturating -1 (00 stays 00); target unchanged.
  - Miss, taken: allocate/replace: valid=1, tag, target, ctr=10 (weakly taken).
  - Miss, not taken: no change.
- Statistics: branch_cnt +1 per upd_valid; mispred_cnt +1 per upd_valid & upd_mispredict. Both wrap at 2^32. upd_mispredict is ignored when upd_valid=0.
- inv_all: clears every valid bit. Tags, targets and counters are left unchanged. Counters and statistics are not affected.
- inv_all and upd_valid in the same cycle: the invalidate wins and no allocation occurs. The statistics still count the update.

## Timing
- Reset (rst=0, async): all valid=0; ctr=01; tags and targets=0; branch_cnt=mispred_cnt=0. As a result, pred_taken=0 and pred_target=0 immediately.
- Lookup latency: 0 cycles (same-cycle combinational from fetch_pc and table state).
- Update latency: 1 cycle. The new state is visible to a lookup in the cycle after the upd_valid edge.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update state (read-old).
- Counter FSM per entry: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Taken moves right and not-taken moves left, saturating at the ends.
- Reset deasserted mid-stream: no update is taken on the first edge unless upd_valid is already valid. Deassertion is synchronised externally.

## Structure
- Shared package bp_pkg: ENTRY_T struct (valid, tag, target, ctr), counter encodings (CTR_SNT, CTR_WNT, CTR_WT, CTR_ST) and a ctr_next(ctr, taken) saturating function.
- One sub-module, bp_counter_stats, holds the two 32-bit statistic counters. Table storage is flip-flops in the top module (no SRAM).

## Test plan
- Reset: assert rst=0 mid-cycle, then look up any PC -> pred_taken=0, pred_target=0, branch_cnt=mispred_cnt=0.
- Allocate/train: update PC 0x100 taken, target 0x40 -> next cycle lookup 0x100 gives pred_taken=1, target 0x40. Two not-taken updates -> pred_taken=0. A third not-taken holds ctr=00, so one taken gives ctr=01 and pred_taken stays 0.
- Saturation: four taken updates on 0x200 -> ctr=11. One not-taken -> still predicts taken. Target changes to 0x300 on a taken update -> pred_target=0x300.
- Alias/replace (ENTRIES=16): train 0x100 taken, then update 0x140 (same index, different tag) taken to 0x80 -> 0x140 predicts 0x80 and 0x100 now misses (pred_taken=0). A not-taken miss on 0x180 leaves the entry unchanged.
- Simultaneous events: lookup 0x100 in the same cycle as its first taken update -> pred_taken=0 that cycle and 1 the next. inv_all together with a taken update -> entry remains invalid, branch_cnt still increments.
- Statistics: 10 updates with 3 mispredicts, plus upd_mispredict pulsed while upd_valid=0 -> branch_cnt=10, mispred_cnt=3. Preload near 2^32-1 via forced state and confirm wrap to 0.
